aes_encryption_iter: RTL and testbench



---
 rtl/aes_encryption_iter.sv | 126 ++++++++++++
 tb/tb_aes_encryption_iter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encryption_iter.sv
// Iterative AES encryption core: one state register reused across rounds, with round
// keys fetched combinationally from an external key schedule addressed by Round_Number.
module aes_encryption_iter #(
  parameter int BLOCK_LENGTH = 128,
  parameter int NR           = 10
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Start,
  input  logic [BLOCK_LENGTH-1:0] PT_In,
  input  logic [BLOCK_LENGTH-1:0] K_i,
  output logic [3:0]              Round_Number,
  output logic [BLOCK_LENGTH-1:0] CT,
  output logic                    Valid,
  output logic                    Busy
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_e                    fsm_q, fsm_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [BLOCK_LENGTH-1:0] state_q, state_d;
  logic [BLOCK_LENGTH-1:0] ct_q, ct_d;
  logic                    valid_q, valid_d;

  logic [127:0] sub_bytes, shift_rows, mix_cols;

  // Byte 0 is the MSB; byte index = 4*column + row, column-major as in FIPS-197.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int COL = gi / 4;
      localparam int ROW = gi % 4;
      localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
      assign sub_bytes[127-8*gi -: 8]  = SBOX[state_q[127-8*gi -: 8]];
      assign shift_rows[127-8*gi -: 8] = sub_bytes[127-8*SRC -: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign {a0, a1, a2, a3} = shift_rows[127-32*gi -: 32];
      assign mix_cols[127-32*gi -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
  endgenerate

  always_comb begin
    fsm_d        = fsm_q;
    cnt_d        = cnt_q;
    state_d      = state_q;
    ct_d         = ct_q;
    valid_d      = 1'b0;
    Round_Number = 4'd0;
    Busy         = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (Start) begin
          state_d = PT_In ^ K_i;
          cnt_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        Round_Number = cnt_q;
        Busy         = 1'b1;
        state_d      = mix_cols ^ K_i;
        cnt_d        = cnt_q + 4'd1;
        if (cnt_q == LAST_ROUND - 4'd1) begin
          fsm_d = FINAL;
        end
      end
      FINAL: begin
        Round_Number = LAST_ROUND;
        Busy         = 1'b1;
        ct_d         = shift_rows ^ K_i;
        valid_d      = 1'b1;
        cnt_d        = 4'd0;
        fsm_d        = IDLE;
      end
      default: begin
        cnt_d = 4'd0;
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fsm_q   <= IDLE;
      cnt_q   <= 4'd0;
      state_q <= '0;
      ct_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      valid_q <= valid_d;
    end
  end

  assign CT    = ct_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_aes_encryption_iter.sv
// Directed bench for aes_encryption_iter: FIPS-197 vectors on NR=10 and NR=14 instances,
// with round keys expanded here and served back by Round_Number.
module tb_aes_encryption_iter;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic         start10, start14;
  logic [127:0] pt10, pt14, k10, k14, ct10, ct14;
  logic [3:0]   rn10, rn14;
  logic         v10, v14, b10, b14;

  logic [127:0] rk10 [0:14];
  logic [127:0] rk14 [0:14];
  logic [7:0]   sbox_m [0:255];

  assign k10 = rk10[rn10];
  assign k14 = rk14[rn14];

  aes_encryption_iter #(.BLOCK_LENGTH(128), .NR(10)) dut10 (
    .CLK(CLK), .RST(RST), .Start(start10), .PT_In(pt10), .K_i(k10),
    .Round_Number(rn10), .CT(ct10), .Valid(v10), .Busy(b10)
  );

  aes_encryption_iter #(.BLOCK_LENGTH(128), .NR(14)) dut14 (
    .CLK(CLK), .RST(RST), .Start(start14), .PT_In(pt14), .K_i(k14),
    .Round_Number(rn14), .CT(ct14), .Valid(v14), .Busy(b14)
  );

  // Observation mux so one sequence task can drive either instance.
  logic         sel14;
  logic [127:0] obs_ct;
  logic [3:0]   obs_rn;
  logic         obs_v, obs_b;
  always_comb begin
    obs_ct = sel14 ? ct14 : ct10;
    obs_rn = sel14 ? rn14 : rn10;
    obs_v  = sel14 ? v14  : v10;
    obs_b  = sel14 ? b14  : b10;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [127:0] model_ct10 = '0;
  logic [127:0] model_ct14 = '0;

  typedef struct {
    int           nr;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs [3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box derived algebraically (GF(2^8) inverse + affine map), independent of any table.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic load_keys(input int nr, input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nk;
    nk   = (nr == 14) ? 8 : 4;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (nr == 14) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else          rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  task automatic drive(input logic st, input logic [127:0] pt);
    if (sel14) begin start14 = st; pt14 = pt; end
    else       begin start10 = st; pt10 = pt; end
  endtask

  // Full encryption: checks Busy/Round_Number/Valid/CT on every cycle T+1..T+NR+1.
  task automatic run_vec(input int i);
    logic [127:0] prev;
    int           nr;
    nr    = vecs[i].nr;
    sel14 = (nr == 14);
    prev  = sel14 ? model_ct14 : model_ct10;
    load_keys(nr, vecs[i].key);
    drive(1'b1, vecs[i].pt);
    chk($sformatf("v%0d_rn_start", i), 128'(obs_rn), 128'd0);
    tick();
    drive(1'b0, vecs[i].pt);
    for (int c = 1; c <= nr + 1; c++) begin
      if (c <= nr) begin
        chk($sformatf("v%0d_busy_c%0d", i, c), 128'(obs_b), 128'd1);
        chk($sformatf("v%0d_rn_c%0d", i, c), 128'(obs_rn), 128'(c));
        chk($sformatf("v%0d_valid_c%0d", i, c), 128'(obs_v), 128'd0);
        chk($sformatf("v%0d_ct_hold_c%0d", i, c), obs_ct, prev);
      end else begin
        chk($sformatf("v%0d_busy_done", i), 128'(obs_b), 128'd0);
        chk($sformatf("v%0d_rn_done", i), 128'(obs_rn), 128'd0);
        chk($sformatf("v%0d_valid_done", i), 128'(obs_v), 128'd1);
        chk($sformatf("v%0d_ct", i), obs_ct, vecs[i].ct);
      end
      tick();
    end
    chk($sformatf("v%0d_valid_pulse_end", i), 128'(obs_v), 128'd0);
    if (sel14) model_ct14 = vecs[i].ct;
    else       model_ct10 = vecs[i].ct;
  endtask

  initial begin
    RST = 1'b0;
    start10 = 1'b0; start14 = 1'b0;
    pt10 = '0; pt14 = '0;
    sel14 = 1'b0;
    for (int r = 0; r < 15; r++) begin rk10[r] = '0; rk14[r] = '0; end

    vecs[0] = '{10, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{10, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{14, {128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f},
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};

    build_sbox();

    repeat (3) tick();
    chk("rst_ct10", ct10, 128'h0);
    chk("rst_valid10", 128'(v10), 128'd0);
    chk("rst_busy10", 128'(b10), 128'd0);
    chk("rst_rn10", 128'(rn10), 128'd0);
    chk("rst_ct14", ct14, 128'h0);
    chk("rst_busy14", 128'(b14), 128'd0);
    RST = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) run_vec(i);

    // Back-to-back: App. B, with a stray Start and PT change mid-flight, then C.1 in the Valid cycle.
    sel14 = 1'b0;
    load_keys(10, vecs[0].key);
    start10 = 1'b1; pt10 = vecs[0].pt;
    tick();
    start10 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c == 3) begin
        start10 = 1'b1;
        pt10 = {$urandom, $urandom, $urandom, $urandom};
      end
      if (c == 4) start10 = 1'b0;
      if (c <= 10) begin
        chk($sformatf("b2b_a_busy_c%0d", c), 128'(b10), 128'd1);
        chk($sformatf("b2b_a_valid_c%0d", c), 128'(v10), 128'd0);
      end else begin
        chk("b2b_a_valid", 128'(v10), 128'd1);
        chk("b2b_a_ct", ct10, vecs[0].ct);
        model_ct10 = vecs[0].ct;
        load_keys(10, vecs[1].key);
        start10 = 1'b1; pt10 = vecs[1].pt;
      end
      tick();
    end
    start10 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c <= 10) begin
        chk($sformatf("b2b_b_valid_c%0d", c), 128'(v10), 128'd0);
        chk($sformatf("b2b_b_rn_c%0d", c), 128'(rn10), 128'(c));
        chk($sformatf("b2b_b_ct_hold_c%0d", c), ct10, model_ct10);
      end else begin
        chk("b2b_b_valid", 128'(v10), 128'd1);
        chk("b2b_b_ct", ct10, vecs[1].ct);
      end
      tick();
    end
    model_ct10 = vecs[1].ct;

    // Asynchronous reset at T+5 discards the encryption in flight.
    load_keys(10, vecs[0].key);
    start10 = 1'b1; pt10 = vecs[0].pt;
    tick();
    start10 = 1'b0;
    repeat (4) tick();
    chk("mid_rst_busy_before", 128'(b10), 128'd1);
    RST = 1'b0;
    #1;
    chk("mid_rst_ct", ct10, 128'h0);
    chk("mid_rst_valid", 128'(v10), 128'd0);
    chk("mid_rst_busy", 128'(b10), 128'd0);
    chk("mid_rst_rn", 128'(rn10), 128'd0);
    model_ct10 = '0;
    tick();
    tick();
    RST = 1'b1;
    for (int c = 0; c < 15; c++) begin
      chk($sformatf("post_rst_valid_c%0d", c), 128'(v10), 128'd0);
      chk($sformatf("post_rst_busy_c%0d", c), 128'(b10), 128'd0);
      tick();
    end
    run_vec(0);

    // Idle hold after a completion.
    sel14 = 1'b0;
    for (int c = 0; c < 50; c++) begin
      chk($sformatf("idle_ct_c%0d", c), ct10, model_ct10);
      chk($sformatf("idle_valid_c%0d", c), 128'(v10), 128'd0);
      chk($sformatf("idle_rn_c%0d", c), 128'(rn10), 128'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
